// File: rtl/cpu_port_responder_pkg.sv
// Shared constants and helpers for the CPU port responder.
// The optional dropped-write counter is built only when RESPONDER_OVF_COUNT_EN is defined.
package cpu_port_pkg;

    localparam int unsigned WORD_W_DEF    = 32;
    localparam int unsigned OUT_DEPTH_DEF = 4;
    localparam int unsigned OVF_CNT_W     = 8;

    typedef logic [OVF_CNT_W-1:0] ovfCount_t;

    localparam ovfCount_t OVF_CNT_MAX = {OVF_CNT_W{1'b1}};
    localparam ovfCount_t OVF_CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

    // Pointer width for a FIFO of the given depth (depth is a power of two).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 32'd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cpu_port_responder_fifo.sv
// Synchronous FIFO holding CPU out-port words until the host takes them.
// Storage is registered; the head word is read straight from the storage array.
module port_fifo
    import cpu_port_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W_DEF,
    parameter int unsigned DEPTH = OUT_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wrPtr_r;
    logic [PTR_W:0]   rdPtr_r;
    logic             doPush_s;
    logic             doPop_s;

    // The extra wrap bit separates full (indices equal, wrap differs) from empty.
    assign empty    = (wrPtr_r == rdPtr_r);
    assign full     = (wrPtr_r[PTR_W-1:0] == rdPtr_r[PTR_W-1:0]) &&
                      (wrPtr_r[PTR_W] != rdPtr_r[PTR_W]);
    assign doPop_s  = pop & ~empty;
    assign doPush_s = push & (~full | doPop_s);
    assign headData = mem_r[rdPtr_r[PTR_W-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk) begin
        if (clr) begin
            wrPtr_r <= PTR_ZERO;
            rdPtr_r <= PTR_ZERO;
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end else begin
                wrPtr_r <= wrPtr_r;
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end else begin
                rdPtr_r <= rdPtr_r;
            end
        end
    end

    // Storage; cleared on reset so the head output reads zero when idle.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (doPush_s) begin
            mem_r[wrPtr_r[PTR_W-1:0]] <= pushData;
        end
    end

endmodule

// File: rtl/cpu_port_responder.sv
// Device-side peer of the CPU in/out ports: out-port words queue to the host, one host word is held for the CPU.
// Define RESPONDER_OVF_COUNT_EN to build the saturating dropped-write counter behind ovf_count.
module cpu_port_responder
    import cpu_port_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 out_wr,
    input  logic [WORD_W-1:0]    out_data,
    input  logic                 in_rd,
    output logic [WORD_W-1:0]    in_data,
    output logic                 in_full,
    output logic [WORD_W-1:0]    host_tx_data,
    output logic                 host_tx_valid,
    input  logic                 host_tx_ready,
    input  logic [WORD_W-1:0]    host_rx_data,
    input  logic                 host_rx_valid,
    output logic                 host_rx_ready,
    output logic                 out_ovf,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    logic fifoFull_s;
    logic fifoEmpty_s;
    logic txPop_s;
    logic txPush_s;
    logic dropWrite_s;
    logic rxLoad_s;

    assign host_tx_valid = ~fifoEmpty_s;
    assign txPop_s       = host_tx_valid & host_tx_ready;
    // A write into a full FIFO still lands if the head leaves in the same cycle.
    assign txPush_s      = out_wr & (~fifoFull_s | txPop_s);
    assign dropWrite_s   = out_wr & fifoFull_s & ~txPop_s;

    assign host_rx_ready = ~in_full | in_rd;
    assign rxLoad_s      = host_rx_valid & host_rx_ready;

    port_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (OUT_DEPTH)
    ) u_outFifo (
        .clk      (clk),
        .clr      (clr),
        .push     (txPush_s),
        .pop      (txPop_s),
        .pushData (out_data),
        .headData (host_tx_data),
        .full     (fifoFull_s),
        .empty    (fifoEmpty_s)
    );

    // Held host word for the CPU in-port; a read only retires the flag, data stays.
    always_ff @(posedge clk) begin
        if (clr) begin
            in_data <= {WORD_W{1'b0}};
            in_full <= 1'b0;
        end else if (rxLoad_s) begin
            in_data <= host_rx_data;
            in_full <= 1'b1;
        end else if (in_rd & in_full) begin
            in_data <= in_data;
            in_full <= 1'b0;
        end else begin
            in_data <= in_data;
            in_full <= in_full;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            out_ovf <= 1'b0;
        end else if (dropWrite_s) begin
            out_ovf <= 1'b1;
        end else begin
            out_ovf <= out_ovf;
        end
    end

`ifdef RESPONDER_OVF_COUNT_EN
    ovfCount_t ovfCount_r;

    // Saturating dropped-write counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            ovfCount_r <= {OVF_CNT_W{1'b0}};
        end else if (dropWrite_s && (ovfCount_r != OVF_CNT_MAX)) begin
            ovfCount_r <= ovfCount_r + OVF_CNT_ONE;
        end else begin
            ovfCount_r <= ovfCount_r;
        end
    end

    assign ovf_count = ovfCount_r;
`else
    assign ovf_count = {OVF_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_port_responder.sv
// Self-checking bench for cpu_port_responder: directed vector table, long overflow sequence,
// then random traffic against a queue-based reference model.
module tb_cpu_port_responder;

    localparam int DEPTH = 4;
`ifdef RESPONDER_OVF_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        clr;
    logic        out_wr;
    logic [31:0] out_data;
    logic        in_rd;
    logic [31:0] in_data;
    logic        in_full;
    logic [31:0] host_tx_data;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic [31:0] host_rx_data;
    logic        host_rx_valid;
    logic        host_rx_ready;
    logic        out_ovf;
    logic [7:0]  ovf_count;

    int nChecks = 0;
    int nFails  = 0;

    cpu_port_responder dut (
        .clk           (clk),
        .clr           (clr),
        .out_wr        (out_wr),
        .out_data      (out_data),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .in_full       (in_full),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .out_ovf       (out_ovf),
        .ovf_count     (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        c;
        logic        w;
        logic [31:0] wd;
        logic        r;
        logic        tr;
        logic        rv;
        logic [31:0] rd;
        logic        eRdy;
        logic        eTv;
        logic [31:0] eTd;
        logic        eIf;
        logic [31:0] eId;
        logic        eOvf;
        logic [7:0]  eCnt;
    } vec_t;

    vec_t vecs[20];

    // reference model state
    logic [31:0] mq[$];
    logic [31:0] mInData;
    bit          mInFull;
    bit          mOvf;
    int          mCnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expCount(input int c);
        return CNT_EN ? 32'(c) : 32'd0;
    endfunction

    function automatic vec_t mkv(input bit c, input bit w, input logic [31:0] wd, input bit r,
                                 input bit tr, input bit rv, input logic [31:0] rd,
                                 input bit eRdy, input bit eTv, input logic [31:0] eTd,
                                 input bit eIf, input logic [31:0] eId, input bit eOvf,
                                 input int eCnt);
        vec_t v;
        v.c = c; v.w = w; v.wd = wd; v.r = r; v.tr = tr; v.rv = rv; v.rd = rd;
        v.eRdy = eRdy; v.eTv = eTv; v.eTd = eTd; v.eIf = eIf; v.eId = eId;
        v.eOvf = eOvf; v.eCnt = 8'(eCnt);
        return v;
    endfunction

    task automatic drive(input bit c, input bit w, input logic [31:0] wd, input bit r,
                         input bit tr, input bit rv, input logic [31:0] rd);
        clr = c; out_wr = w; out_data = wd; in_rd = r;
        host_tx_ready = tr; host_rx_valid = rv; host_rx_data = rd;
    endtask

    // Advance the reference model by one clock using the currently driven inputs.
    task automatic modelStep();
        bit pop, accept, rdy;
        if (clr) begin
            mq.delete();
            mInData = 32'd0; mInFull = 1'b0; mOvf = 1'b0; mCnt = 0;
        end else begin
            pop    = (mq.size() > 0) && host_tx_ready;
            accept = out_wr && ((mq.size() < DEPTH) || pop);
            rdy    = !mInFull || in_rd;
            if (out_wr && !accept) begin
                mOvf = 1'b1;
                if (mCnt < 255) mCnt++;
            end
            if (pop) void'(mq.pop_front());
            if (accept) mq.push_back(out_data);
            if (host_rx_valid && rdy) begin
                mInData = host_rx_data; mInFull = 1'b1;
            end else if (in_rd && mInFull) begin
                mInFull = 1'b0;
            end
        end
    endtask

    task automatic checkModel(input string tag);
        check({tag, " txValid"}, {31'd0, host_tx_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) check({tag, " txData"}, host_tx_data, mq[0]);
        check({tag, " inFull"}, {31'd0, in_full}, {31'd0, mInFull});
        check({tag, " inData"}, in_data, mInData);
        check({tag, " ovf"}, {31'd0, out_ovf}, {31'd0, mOvf});
        check({tag, " cnt"}, {24'd0, ovf_count}, expCount(mCnt));
    endtask

    initial begin
        drive(1'b0, 1'b1, 32'hFFFF0000, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);

        vecs[0]  = mkv(1,1,32'hDEADBEEF,1,1,1,32'hCAFEF00D, 1,0,32'h0,0,32'h0,0,0);
        vecs[1]  = mkv(0,1,32'h11,0,1,0,32'h0,          1,1,32'h11,0,32'h0,0,0);
        vecs[2]  = mkv(0,1,32'h22,0,1,0,32'h0,          1,1,32'h22,0,32'h0,0,0);
        vecs[3]  = mkv(0,1,32'h33,0,1,0,32'h0,          1,1,32'h33,0,32'h0,0,0);
        vecs[4]  = mkv(0,0,32'h0,0,1,0,32'h0,           1,0,32'h0,0,32'h0,0,0);
        vecs[5]  = mkv(0,1,32'h01,0,0,0,32'h0,          1,1,32'h01,0,32'h0,0,0);
        vecs[6]  = mkv(0,1,32'h02,0,0,0,32'h0,          1,1,32'h01,0,32'h0,0,0);
        vecs[7]  = mkv(0,1,32'h03,0,0,0,32'h0,          1,1,32'h01,0,32'h0,0,0);
        vecs[8]  = mkv(0,1,32'h04,0,0,0,32'h0,          1,1,32'h01,0,32'h0,0,0);
        vecs[9]  = mkv(0,1,32'h05,0,0,0,32'h0,          1,1,32'h01,0,32'h0,1,1);
        vecs[10] = mkv(0,1,32'h55,0,1,0,32'h0,          1,1,32'h02,0,32'h0,1,1);
        vecs[11] = mkv(0,0,32'h0,0,0,1,32'hA5A5A5A5,    1,1,32'h02,1,32'hA5A5A5A5,1,1);
        vecs[12] = mkv(0,0,32'h0,0,0,0,32'h0,           0,1,32'h02,1,32'hA5A5A5A5,1,1);
        vecs[13] = mkv(0,0,32'h0,1,0,1,32'h5A5A5A5A,    1,1,32'h02,1,32'h5A5A5A5A,1,1);
        vecs[14] = mkv(0,0,32'h0,1,0,0,32'h0,           1,1,32'h02,0,32'h5A5A5A5A,1,1);
        vecs[15] = mkv(0,0,32'h0,1,0,0,32'h0,           1,1,32'h02,0,32'h5A5A5A5A,1,1);
        vecs[16] = mkv(0,0,32'h0,0,1,1,32'h12345678,    1,1,32'h03,1,32'h12345678,1,1);
        vecs[17] = mkv(0,0,32'h0,0,1,0,32'h0,           0,1,32'h04,1,32'h12345678,1,1);
        vecs[18] = mkv(1,1,32'h77,1,1,1,32'h99,         1,0,32'h0,0,32'h0,0,0);
        vecs[19] = mkv(0,0,32'h0,0,0,0,32'h0,           1,0,32'h0,0,32'h0,0,0);

        // directed vector table
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].c, vecs[i].w, vecs[i].wd, vecs[i].r, vecs[i].tr, vecs[i].rv, vecs[i].rd);
            #1;
            if (!vecs[i].c)
                check($sformatf("v%0d rxReady", i), {31'd0, host_rx_ready}, {31'd0, vecs[i].eRdy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d txValid", i), {31'd0, host_tx_valid}, {31'd0, vecs[i].eTv});
            if (vecs[i].eTv || vecs[i].c)
                check($sformatf("v%0d txData", i), host_tx_data, vecs[i].eTd);
            check($sformatf("v%0d inFull", i), {31'd0, in_full}, {31'd0, vecs[i].eIf});
            check($sformatf("v%0d inData", i), in_data, vecs[i].eId);
            check($sformatf("v%0d ovf", i), {31'd0, out_ovf}, {31'd0, vecs[i].eOvf});
            check($sformatf("v%0d cnt", i), {24'd0, ovf_count}, expCount(int'(vecs[i].eCnt)));
        end

        // long overflow run: fill 4, then 300 dropped writes
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 304; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 32'd1000 + 32'(k), 1'b0, 1'b0, 1'b0, 32'd0);
            @(posedge clk);
            #1;
            if (k == 103) check("sat mid cnt", {24'd0, ovf_count}, expCount(100));
            if (k == 258) check("sat at max cnt", {24'd0, ovf_count}, expCount(255));
        end
        check("sat final cnt", {24'd0, ovf_count}, expCount(255));
        check("sat ovf", {31'd0, out_ovf}, 32'd1);
        check("sat head", host_tx_data, 32'd1000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
            #1;
            check($sformatf("drain%0d valid", k), {31'd0, host_tx_valid}, 32'd1);
            check($sformatf("drain%0d data", k), host_tx_data, 32'd1000 + 32'(k));
            @(posedge clk);
        end
        #1;
        check("drain empty", {31'd0, host_tx_valid}, 32'd0);
        check("drain ovf sticky", {31'd0, out_ovf}, 32'd1);

        // random traffic against the reference model
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        modelStep();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            drive($urandom_range(99) == 0, $urandom_range(9) < 6, $urandom,
                  $urandom_range(9) < 4, $urandom_range(1) == 1,
                  $urandom_range(1) == 1, $urandom);
            #1;
            if (!clr)
                check($sformatf("r%0d rxReady", n), {31'd0, host_rx_ready},
                      {31'd0, (!mInFull || in_rd)});
            @(posedge clk);
            modelStep();
            #1;
            checkModel($sformatf("r%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
